gfx_cmd_assembler: RTL and testbench
====================================

Name: gfx_cmd_assembler

Overview:
Upstream stage of the line drawing engine. Collects a host byte stream (UART/SPI receive side) into 128-bit graphics ops and decodes the opcode byte. Line ops go to the line drawing engine's op input; rectangle/fill ops go to the auxiliary engine port. Also handles inter-byte timeout resync, NOP discard and illegal-opcode counting.

Parameters:
TIMEOUT_CYCLES, 1024, idle cycles allowed between bytes of one op before the partial op is discarded
TO_LOG2, 10, width of the idle timer (TIMEOUT_CYCLES <= 2**TO_LOG2)

Ports:
clk  input  1  system clock
rst_  input  1  reset, asynchronous, active-low
in_byte  input  8  host command byte
in_rts  input  1  host byte valid
in_rtr  output  1  assembler can accept a byte
line_op  output  128  assembled line op, to line drawing engine in_op
line_rts  output  1  line_op valid
line_rtr  input  1  line drawing engine accepts
aux_op  output  128  assembled auxiliary op (fill/clear engine)
aux_rts  output  1  aux_op valid
aux_rtr  input  1  auxiliary engine accepts
err_cnt  output  8  saturating count of dropped ops (illegal opcode or timeout)

Behaviour:
- One clock, clk; reset rst_ is asynchronous and active-low. Reset values: in_rtr=0 during reset, 1 on the first cycle after release; line_rts=0, aux_rts=0, line_op=0, aux_op=0, err_cnt=0, byte count=0, timer=0, state=COLLECT.
- Transfer on any interface happens when rts&&rtr on a rising clk edge.
- Byte order: k-th accepted byte of an op (k=0..15) is stored at op[8k+7:8k]. Multi-byte fields are sent MSB first: bytes 0-1 x1, 2-3 y1, 4-5 x2, 6-7 y2, bytes 8-10 colour, byte 15 = opcode (op[127:120]). Bytes 11-14 are reserved and passed through unchanged.
- Opcodes: 0x00 NOP, 0x01 LINE, 0x02 AUX. All others are illegal.
- States:
  - COLLECT: in_rtr=1. Each accepted byte is written, count increments, timer clears. Accepting byte 15 decodes it in the same edge:
    - LINE: op goes to the line_op register, line_rts=1, go to SEND_LINE.
    - AUX: op goes to the aux_op register, aux_rts=1, go to SEND_AUX.
    - NOP: discarded silently, stay in COLLECT.
    - Illegal: discarded, err_cnt+1, stay in COLLECT.
    - In every case count returns to 0.
  - SEND_LINE / SEND_AUX: in_rtr=0. rts and op are held stable until the handshake; rts is never retracted. On line_rtr (aux_rtr) the rts drops next cycle and the state returns to COLLECT.
- Latency: op valid on the cycle after the 16th byte is accepted. Minimum op period is 17 cycles (16 bytes + 1 send cycle when rtr=1). rtr already high when rts rises completes the handshake on that first cycle.
- Idle timer:
  - Runs only in COLLECT with count != 0. It increments each cycle without an accepted byte.
  - When it reaches TIMEOUT_CYCLES-1 with no byte that cycle, the next edge clears count and timer and increments err_cnt.
  - If a byte is accepted on the expiry cycle, the byte wins: it is stored and the timer clears.
  - The timer is held at 0 while count==0 or in SEND states.
- err_cnt saturates at 255. An illegal opcode and a timeout cannot coincide.
- Only one of line_rts / aux_rts is ever high.
- Reset asserted mid-op or mid-send aborts immediately. Partial bytes are lost, and rts drops asynchronously.
- Opcode decode is combinational on in_byte at byte 15. All outputs are registered.

Decomposition:
- Package gfx_cmd_pkg holds:
  - Opcode constants: OP_NOP, OP_LINE, OP_AUX.
  - OP_BYTES=16 and OPCODE_BYTE=15.
  - Field byte offsets: X1_B=0, Y1_B=2, X2_B=4, Y2_B=6, COLOR_B=8.
  - State encoding constants.
- One sub-module: gfx_idle_timer (clear / enable / expired, parameterised by TIMEOUT_CYCLES and TO_LOG2).
- Assembler FSM and registers stay in gfx_cmd_assembler.

Test Plan:
- Send 16 bytes 00 0A 00 14 00 64 00 C8 0F 0F 00 00 00 00 00 01 with in_rts always high and line_rtr=1 -> line_op[15:0]=16'h0A00, byte 15=0x01, line_rts high exactly 1 cycle starting 1 cycle after the last byte; aux_rts stays 0.
- Same op but opcode 0x02 with aux_rtr held 0 for 20 cycles -> aux_rts and aux_op stable for all 20 cycles, in_rtr=0 throughout; transfer completes on the cycle aux_rtr rises.
- Opcode 0x7F, then a valid LINE op -> err_cnt=1, no rts for the illegal op; the following LINE op is delivered correctly, proving byte alignment is kept.
- TIMEOUT_CYCLES=8: send 5 bytes, idle 8 cycles, then send a full LINE op -> err_cnt=1 and the LINE op is decoded cleanly. Repeat with a byte arriving exactly on cycle 7 of idle -> no timeout, err_cnt unchanged.
- NOP opcode 0x00 -> no rts on either port, err_cnt unchanged; 300 illegal ops -> err_cnt saturates at 255.
- Assert rst_ mid-op at byte 9 and again during SEND_LINE -> line_rts=0 and err_cnt=0 asynchronously; the next full op after release is delivered correctly.

Source files
------------

// File: rtl/gfx_cmd_pkg.sv
// Shared constants for the graphics command assembler: opcodes, op layout, FSM states.
package gfx_cmd_pkg;

    // Opcode byte values carried in the last byte of every op
    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_LINE = 8'h01;
    localparam logic [7:0] OP_AUX  = 8'h02;

    // Op geometry: 16 bytes, the opcode is the last one
    localparam int OP_BYTES    = 16;
    localparam int OPCODE_BYTE = 15;
    localparam int OP_W        = OP_BYTES * 8;

    // Byte offsets of the fields inside an op (multi-byte fields are sent MSB first)
    localparam int X1_B    = 0;
    localparam int Y1_B    = 2;
    localparam int X2_B    = 4;
    localparam int Y2_B    = 6;
    localparam int COLOR_B = 8;

    // Assembler states
    typedef enum logic [1:0] {
        ST_COLLECT   = 2'd0,
        ST_SEND_LINE = 2'd1,
        ST_SEND_AUX  = 2'd2
    } state_t;

endpackage

// File: rtl/gfx_idle_timer.sv
// Inter-byte idle timer: counts idle cycles while enabled and flags the cycle on
// which the last allowed idle cycle is reached. Clear or a disabled cycle holds it at 0.
module gfx_idle_timer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_LOG2        = 10
) (
    input  logic clk,
    input  logic rst_,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_LOG2-1:0] TMR_LAST = TO_LOG2'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_LOG2-1:0] TMR_ONE  = TO_LOG2'(1);
    localparam logic [TO_LOG2-1:0] TMR_ZERO = {TO_LOG2{1'b0}};

    logic [TO_LOG2-1:0] tmr_r;
    logic [TO_LOG2-1:0] tmr_nxt_s;

    assign expired = enable && (tmr_r == TMR_LAST);

    // Next timer value: wrap to zero on expiry so the partial op restarts cleanly
    always_comb begin
        tmr_nxt_s = tmr_r;
        if (clear || !enable || expired) begin
            tmr_nxt_s = TMR_ZERO;
        end else begin
            tmr_nxt_s = tmr_r + TMR_ONE;
        end
    end

    // Timer register
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            tmr_r <= TMR_ZERO;
        end else begin
            tmr_r <= tmr_nxt_s;
        end
    end

endmodule

// File: rtl/gfx_cmd_assembler.sv
// Assembles a host byte stream into 128-bit graphics ops, decodes the opcode byte
// and hands LINE ops to the line engine and AUX ops to the auxiliary engine.
// NOPs are dropped silently; illegal opcodes and inter-byte timeouts bump err_cnt.
module gfx_cmd_assembler
    import gfx_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_LOG2        = 10
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic [7:0]      in_byte,
    input  logic            in_rts,
    output logic            in_rtr,
    output logic [OP_W-1:0] line_op,
    output logic            line_rts,
    input  logic            line_rtr,
    output logic [OP_W-1:0] aux_op,
    output logic            aux_rts,
    input  logic            aux_rtr,
    output logic [7:0]      err_cnt
);

    localparam int                CNT_W    = $clog2(OP_BYTES);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(OPCODE_BYTE);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [OP_W-1:0]   OP_ZERO  = {OP_W{1'b0}};

    state_t            state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [OP_W-9:0]   buf_r;
    logic [OP_W-1:0]   full_op_s;
    logic [OP_W-1:0]   line_op_r, line_op_nxt_s;
    logic [OP_W-1:0]   aux_op_r, aux_op_nxt_s;
    logic              line_rts_r, line_rts_nxt_s;
    logic              aux_rts_r, aux_rts_nxt_s;
    logic              in_rtr_r, in_rtr_nxt_s;
    logic [7:0]        err_r, err_nxt_s;
    logic              err_inc_s;
    logic              accept_s;
    logic              tmr_en_s, tmr_clr_s, tmr_exp_s;

    // Bytes shift in from the top, so after 15 bytes byte k sits at bits [8k+7:8k]
    assign accept_s  = in_rts && in_rtr_r;
    assign full_op_s = {in_byte, buf_r};
    assign tmr_en_s  = (state_r == ST_COLLECT) && (cnt_r != CNT_ZERO) && !accept_s;
    assign tmr_clr_s = !tmr_en_s;

    gfx_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_LOG2        (TO_LOG2)
    ) u_idle_timer (
        .clk     (clk),
        .rst_    (rst_),
        .clear   (tmr_clr_s),
        .enable  (tmr_en_s),
        .expired (tmr_exp_s)
    );

    // Next-state, byte count, opcode decode and output register inputs
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        line_op_nxt_s  = line_op_r;
        aux_op_nxt_s   = aux_op_r;
        line_rts_nxt_s = line_rts_r;
        aux_rts_nxt_s  = aux_rts_r;
        err_inc_s      = 1'b0;
        case (state_r)
            ST_COLLECT: begin
                if (accept_s) begin
                    if (cnt_r == LAST_IDX) begin
                        cnt_nxt_s = CNT_ZERO;
                        case (in_byte)
                            OP_LINE: begin
                                line_op_nxt_s  = full_op_s;
                                line_rts_nxt_s = 1'b1;
                                state_nxt_s    = ST_SEND_LINE;
                            end
                            OP_AUX: begin
                                aux_op_nxt_s  = full_op_s;
                                aux_rts_nxt_s = 1'b1;
                                state_nxt_s   = ST_SEND_AUX;
                            end
                            OP_NOP:  err_inc_s = 1'b0;
                            default: err_inc_s = 1'b1;
                        endcase
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end else if (tmr_exp_s) begin
                    cnt_nxt_s = CNT_ZERO;
                    err_inc_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_SEND_LINE: begin
                if (line_rtr) begin
                    line_rts_nxt_s = 1'b0;
                    state_nxt_s    = ST_COLLECT;
                end else begin
                    line_rts_nxt_s = 1'b1;
                end
            end
            ST_SEND_AUX: begin
                if (aux_rtr) begin
                    aux_rts_nxt_s = 1'b0;
                    state_nxt_s   = ST_COLLECT;
                end else begin
                    aux_rts_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s    = ST_COLLECT;
                cnt_nxt_s      = CNT_ZERO;
                line_rts_nxt_s = 1'b0;
                aux_rts_nxt_s  = 1'b0;
            end
        endcase
        in_rtr_nxt_s = (state_nxt_s == ST_COLLECT) ? 1'b1 : 1'b0;
        err_nxt_s    = (err_inc_s && (err_r != 8'hFF)) ? (err_r + 8'd1) : err_r;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_r <= ST_COLLECT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Byte count, handshake flags, op registers and error counter
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt_r      <= CNT_ZERO;
            line_op_r  <= OP_ZERO;
            aux_op_r   <= OP_ZERO;
            line_rts_r <= 1'b0;
            aux_rts_r  <= 1'b0;
            in_rtr_r   <= 1'b0;
            err_r      <= 8'd0;
        end else begin
            cnt_r      <= cnt_nxt_s;
            line_op_r  <= line_op_nxt_s;
            aux_op_r   <= aux_op_nxt_s;
            line_rts_r <= line_rts_nxt_s;
            aux_rts_r  <= aux_rts_nxt_s;
            in_rtr_r   <= in_rtr_nxt_s;
            err_r      <= err_nxt_s;
        end
    end

    // Assembly buffer for bytes 0..14 of the op in progress
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            buf_r <= {(OP_W-8){1'b0}};
        end else if (accept_s) begin
            buf_r <= full_op_s[OP_W-1:8];
        end else begin
            buf_r <= buf_r;
        end
    end

    assign in_rtr   = in_rtr_r;
    assign line_op  = line_op_r;
    assign line_rts = line_rts_r;
    assign aux_op   = aux_op_r;
    assign aux_rts  = aux_rts_r;
    assign err_cnt  = err_r;

endmodule

// File: tb/tb_gfx_cmd_assembler.sv
// Self-checking bench for gfx_cmd_assembler: per-cycle transaction-level reference
// model, a table of directed ops, hand-written timeout/reset sequences and random traffic.
module tb_gfx_cmd_assembler;
    import gfx_cmd_pkg::*;

    localparam int TMO = 8;
    localparam logic [127:0] BASE = 128'h0100000000000F0FC800640014000A00;

    logic         clk = 1'b0;
    logic         rst_ = 1'b1;
    logic [7:0]   in_byte = 8'd0;
    logic         in_rts = 1'b0;
    logic         in_rtr;
    logic [127:0] line_op;
    logic         line_rts;
    logic         line_rtr = 1'b0;
    logic [127:0] aux_op;
    logic         aux_rts;
    logic         aux_rtr = 1'b0;
    logic [7:0]   err_cnt;

    gfx_cmd_assembler #(.TIMEOUT_CYCLES(TMO), .TO_LOG2(4)) dut (
        .clk(clk), .rst_(rst_), .in_byte(in_byte), .in_rts(in_rts), .in_rtr(in_rtr),
        .line_op(line_op), .line_rts(line_rts), .line_rtr(line_rtr),
        .aux_op(aux_op), .aux_rts(aux_rts), .aux_rtr(aux_rtr), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state (abstract: bytes received so far, pending op, error count)
    logic [7:0]   m_q[$];
    int           m_idle = 0;
    int           m_pend = 0;    // 0 none, 1 line, 2 aux
    logic [127:0] m_op = '0;
    int           m_err = 0;
    bit           m_rdy = 0;
    bit           e_rtr = 0;
    bit           last_acc = 0;

    int           hi_line = 0, hi_aux = 0;
    logic [127:0] cap_line = '0, cap_aux = '0;
    int           tb_err = 0;

    typedef struct {
        logic [7:0] opc;
        int         wait_c;
        int         exp_line_hi;
        int         exp_aux_hi;
        int         exp_err_inc;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    function automatic logic [127:0] mk(input logic [7:0] opc);
        logic [127:0] o;
        o = BASE;
        o[127:120] = opc;
        return o;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_idle = 0;
        m_pend = 0;
        m_err  = 0;
        m_rdy  = 0;
    endtask

    // One clock cycle: compare outputs at negedge, advance the model at posedge
    task automatic step();
        logic [127:0] o;
        bit acc;
        @(negedge clk);
        e_rtr = m_rdy && (m_pend == 0);
        check("in_rtr", in_rtr, e_rtr);
        check("line_rts", line_rts, m_pend == 1);
        check("aux_rts", aux_rts, m_pend == 2);
        check("err_cnt", err_cnt, m_err[7:0]);
        if (m_pend == 1) check("line_op", line_op, m_op);
        if (m_pend == 2) check("aux_op", aux_op, m_op);
        if (line_rts) begin hi_line++; cap_line = line_op; end
        if (aux_rts)  begin hi_aux++;  cap_aux  = aux_op;  end
        @(posedge clk);
        acc = 0;
        if (!rst_) begin
            model_reset();
        end else begin
            acc = in_rts && e_rtr;
            if (m_pend == 1 && line_rtr) m_pend = 0;
            else if (m_pend == 2 && aux_rtr) m_pend = 0;
            if (acc) begin
                m_q.push_back(in_byte);
                m_idle = 0;
                if (m_q.size() == OP_BYTES) begin
                    for (int k = 0; k < OP_BYTES; k++) o[8*k +: 8] = m_q[k];
                    if (m_q[OPCODE_BYTE] == 8'h01) begin m_pend = 1; m_op = o; end
                    else if (m_q[OPCODE_BYTE] == 8'h02) begin m_pend = 2; m_op = o; end
                    else if (m_q[OPCODE_BYTE] != 8'h00) m_err = sat_inc(m_err);
                    m_q.delete();
                end
            end else if (m_q.size() != 0) begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_q.delete();
                    m_idle = 0;
                    m_err = sat_inc(m_err);
                end
            end
            m_rdy = 1;
        end
        last_acc = acc;
        #1;
    endtask

    // Send bytes lo..hi of op, waiting (bounded) for each to be accepted
    task automatic send_range(input logic [127:0] op, input int lo, input int hi);
        bit acc;
        for (int k = lo; k <= hi; k++) begin
            in_byte = op[8*k +: 8];
            in_rts  = 1'b1;
            acc = 0;
            for (int n = 0; n < 200 && !acc; n++) begin
                step();
                acc = last_acc;
            end
            n_checks++;
            if (!acc) begin
                n_err++;
                $display("FAIL send_byte: byte %0d accepted=0 required=1", k);
            end
        end
        in_rts = 1'b0;
    endtask

    task automatic send_op(input logic [127:0] op);
        send_range(op, 0, OP_BYTES - 1);
    endtask

    // Assert reset half-way through a cycle and check outputs clear without a clock edge
    task automatic async_reset();
        #2 rst_ = 1'b0;
        #1;
        check("async_line_rts", line_rts, 1'b0);
        check("async_aux_rts", aux_rts, 1'b0);
        check("async_err_cnt", err_cnt, 8'd0);
        check("async_in_rtr", in_rtr, 1'b0);
        model_reset();
        tb_err = 0;
        step();
        step();
        rst_ = 1'b1;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h01, 0,  1, 0,  0};
        vecs[1] = '{8'h02, 20, 0, 21, 0};
        vecs[2] = '{8'h7F, 0,  0, 0,  1};
        vecs[3] = '{8'h01, 3,  4, 0,  0};
        vecs[4] = '{8'h00, 0,  0, 0,  0};
        vecs[5] = '{8'h02, 0,  0, 1,  0};
        vecs[6] = '{8'hFF, 0,  0, 0,  1};
        vecs[7] = '{8'h01, 5,  6, 0,  0};

        // Reset state
        #1 rst_ = 1'b0;
        repeat (3) step();
        check("reset_line_op", line_op, 128'd0);
        check("reset_aux_op", aux_op, 128'd0);
        rst_ = 1'b1;
        step();
        check("in_rtr_after_release", in_rtr, 1'b1);

        // Basic LINE op with the receiver always ready
        line_rtr = 1'b1; aux_rtr = 1'b1;
        hi_line = 0; hi_aux = 0;
        send_op(BASE);
        repeat (3) step();
        check("line_hi_cycles", hi_line, 1);
        check("aux_hi_cycles", hi_aux, 0);
        check("x1", cap_line[X1_B*8 +: 16], 16'h0A00);
        check("y1", cap_line[Y1_B*8 +: 16], 16'h1400);
        check("x2", cap_line[X2_B*8 +: 16], 16'h6400);
        check("y2", cap_line[Y2_B*8 +: 16], 16'hC800);
        check("color", cap_line[COLOR_B*8 +: 24], 24'h000F0F);
        check("opcode", cap_line[OPCODE_BYTE*8 +: 8], 8'h01);

        // Table of directed ops
        for (int i = 0; i < 8; i++) begin
            hi_line = 0; hi_aux = 0;
            line_rtr = (vecs[i].wait_c == 0);
            aux_rtr  = (vecs[i].wait_c == 0);
            send_op(mk(vecs[i].opc));
            repeat (vecs[i].wait_c) step();
            line_rtr = 1'b1; aux_rtr = 1'b1;
            repeat (3) step();
            check("vec_line_hi", hi_line, vecs[i].exp_line_hi);
            check("vec_aux_hi", hi_aux, vecs[i].exp_aux_hi);
            if (vecs[i].exp_line_hi > 0) check("vec_line_op", cap_line, mk(vecs[i].opc));
            if (vecs[i].exp_aux_hi > 0) check("vec_aux_op", cap_aux, mk(vecs[i].opc));
            tb_err = tb_err + vecs[i].exp_err_inc;
            check("vec_err_cnt", err_cnt, tb_err[7:0]);
        end

        // Timeout: 5 bytes then 8 idle cycles drops the partial op
        send_range(BASE, 0, 4);
        repeat (TMO) step();
        tb_err = tb_err + 1;
        check("timeout_err", err_cnt, tb_err[7:0]);
        hi_line = 0;
        send_op(BASE);
        repeat (3) step();
        check("post_timeout_line_hi", hi_line, 1);
        check("post_timeout_line_op", cap_line, BASE);

        // A byte arriving on the last idle cycle wins over the timeout
        hi_line = 0;
        send_range(BASE, 0, 4);
        repeat (TMO - 1) step();
        send_range(BASE, 5, 15);
        repeat (3) step();
        check("edge_idle_err", err_cnt, tb_err[7:0]);
        check("edge_idle_line_hi", hi_line, 1);
        check("edge_idle_line_op", cap_line, BASE);

        // Saturation of the error counter
        for (int i = 0; i < 300; i++) begin
            send_op(mk(8'h7F));
            tb_err = sat_inc(tb_err);
        end
        step();
        check("err_saturated", err_cnt, 8'd255);

        // Reset in the middle of an op (after byte 9)
        send_range(BASE, 0, 8);
        async_reset();
        hi_line = 0;
        send_op(BASE);
        repeat (3) step();
        check("rst_mid_op_line_hi", hi_line, 1);
        check("rst_mid_op_line_op", cap_line, BASE);

        // Reset while a LINE op waits for the engine
        line_rtr = 1'b0;
        send_op(mk(8'h7F));
        send_op(BASE);
        repeat (2) step();
        async_reset();
        line_rtr = 1'b1;
        hi_line = 0;
        send_op(mk(8'h01));
        repeat (3) step();
        check("rst_send_line_hi", hi_line, 1);
        check("rst_send_line_op", cap_line, mk(8'h01));
        check("rst_send_err", err_cnt, 8'd0);

        // Random traffic against the model
        begin
            int idle_left = 0;
            for (int c = 0; c < 3000; c++) begin
                if (idle_left > 0) begin
                    in_rts = 1'b0;
                    idle_left--;
                end else begin
                    if ($urandom_range(0, 39) == 0) idle_left = $urandom_range(5, 12);
                    in_rts = ($urandom_range(0, 4) != 0);
                end
                if (m_q.size() == OPCODE_BYTE) begin
                    case ($urandom_range(0, 4))
                        0: in_byte = 8'h00;
                        1: in_byte = 8'h01;
                        2: in_byte = 8'h02;
                        3: in_byte = 8'h01;
                        default: in_byte = 8'($urandom);
                    endcase
                end else begin
                    in_byte = 8'($urandom);
                end
                line_rtr = ($urandom_range(0, 2) != 0);
                aux_rtr  = ($urandom_range(0, 2) != 0);
                step();
            end
            in_rts = 1'b0; line_rtr = 1'b1; aux_rtr = 1'b1;
            repeat (4) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
